// File: rtl/bin2seg_display_if.sv
// Bus bundle for bin2seg_display: conversion handshake, BCD result and multiplexed display drive.
interface bin2seg_display_if;
  logic [7:0]  value;
  logic        load;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic [6:0]  seg_n;
  logic [2:0]  an_n;

  modport master (output value, load, input busy, done, bcd, seg_n, an_n);
  modport slave  (input value, load, output busy, done, bcd, seg_n, an_n);
endinterface

// File: rtl/bin2seg_display.sv
// 8-bit binary to 3-digit BCD converter (double-dabble, 8 iterations) driving a
// time-multiplexed, active-low 7-segment display with optional leading-zero blanking.
module bin2seg_display #(
  parameter int unsigned REFRESH_DIV = 1000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input logic               clk,
  input logic               clr,
  bin2seg_display_if.slave  bus
);

  localparam int unsigned DivW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e         state_q, state_d;
  logic [19:0]    sr_q, sr_d, step;
  logic [2:0]     iter_q, iter_d;
  logic [11:0]    bcd_q, bcd_d;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]     dig_q, dig_d;
  logic [6:0]     seg_q, seg_d;
  logic [2:0]     an_q, an_d;
  logic [3:0]     nib;
  logic           blank;

  // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left.
  function automatic logic [19:0] dabble(input logic [19:0] r);
    logic [19:0] t;
    t = r;
    if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
    return {t[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;
    step    = dabble(sr_q);
    unique case (state_q)
      StIdle: begin
        if (bus.load) begin
          sr_d    = {12'd0, bus.value};
          iter_d  = 3'd0;
          state_d = StConv;
        end
      end
      StConv: begin
        sr_d   = step;
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          bcd_d   = step[19:8];
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Display path runs off the next-state digit and result so an_n and seg_n update together.
  always_comb begin
    div_d = div_q + DivW'(1);
    dig_d = dig_q;
    if (div_q == DivLast) begin
      div_d = '0;
      dig_d = (dig_q == 2'd2) ? 2'd0 : dig_q + 2'd1;
    end
    case (dig_d)
      2'd0: begin
        nib   = bcd_d[3:0];
        blank = 1'b0;
        an_d  = 3'b110;
      end
      2'd1: begin
        nib   = bcd_d[7:4];
        blank = BLANK_LZ && (bcd_d[11:4] == 8'd0);
        an_d  = 3'b101;
      end
      default: begin
        nib   = bcd_d[11:8];
        blank = BLANK_LZ && (bcd_d[11:8] == 4'd0);
        an_d  = 3'b011;
      end
    endcase
    seg_d = blank ? 7'b1111111 : enc(nib);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      sr_q    <= '0;
      iter_q  <= '0;
      bcd_q   <= '0;
      div_q   <= '0;
      dig_q   <= '0;
      seg_q   <= 7'b1000000;
      an_q    <= 3'b110;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      iter_q  <= iter_d;
      bcd_q   <= bcd_d;
      div_q   <= div_d;
      dig_q   <= dig_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign bus.busy  = (state_q != StIdle);
  assign bus.done  = (state_q == StDone);
  assign bus.bcd   = bcd_q;
  assign bus.seg_n = seg_q;
  assign bus.an_n  = an_q;

endmodule

// File: tb/tb_bin2seg_display.sv
// Scoreboard bench for bin2seg_display: two instances (blanking on/off) share stimulus and are
// checked against an arithmetic reference of conversion timing, result and display scan.
module tb_bin2seg_display;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  bin2seg_display_if ifa ();
  bin2seg_display_if ifb ();

  bin2seg_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) u_a (.clk(clk), .clr(clr), .bus(ifa));
  bin2seg_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) u_b (.clk(clk), .clr(clr), .bus(ifb));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input logic [7:0] v);
    int n;
    n = int'(v);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [6:0] seg_of(input int n);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return tbl[n];
  endfunction

  function automatic logic [6:0] exp_seg(input logic [11:0] b, input int d, input bit blz);
    int h, t, u;
    h = int'(b[11:8]);
    t = int'(b[7:4]);
    u = int'(b[3:0]);
    if (d == 0) return seg_of(u);
    if (d == 1) return (blz && h == 0 && t == 0) ? 7'h7F : seg_of(t);
    return (blz && h == 0) ? 7'h7F : seg_of(h);
  endfunction

  // Inputs as seen at each rising edge.
  logic       clr_q  = 1'b0;
  logic       load_q = 1'b0;
  logic [7:0] val_q  = 8'd0;
  always @(posedge clk) begin
    clr_q  <= clr;
    load_q <= ifa.load;
    val_q  <= ifa.value;
  end

  bit          started = 1'b0;
  int          k = 0;
  int          rem = 0;
  int          d;
  logic [11:0] model_bcd = 12'd0;
  logic [11:0] exp_q [$];
  logic [2:0]  an_exp;

  always @(negedge clk) begin
    // Predictor: an accepted load keeps the block busy for 9 cycles, done on the last one.
    if (clr_q) begin
      started   = 1'b1;
      k         = 0;
      rem       = 0;
      model_bcd = 12'd0;
      exp_q.delete();
    end else begin
      k++;
      if (rem > 0) rem--;
      else if (load_q) begin
        rem = 9;
        exp_q.push_back(to_bcd(val_q));
      end
    end
    if (started) begin
      chk("busy_a", 32'(ifa.busy), 32'(rem > 0));
      chk("busy_b", 32'(ifb.busy), 32'(rem > 0));
      chk("done_a", 32'(ifa.done), 32'(rem == 1));
      chk("done_b", 32'(ifb.done), 32'(rem == 1));
      if (ifa.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_empty at %0t: got done expected no result", $time);
        end else begin
          model_bcd = exp_q.pop_front();
        end
      end
      chk("bcd_a", 32'(ifa.bcd), 32'(model_bcd));
      chk("bcd_b", 32'(ifb.bcd), 32'(model_bcd));
      d = (k / 4) % 3;
      an_exp = (d == 0) ? 3'b110 : (d == 1) ? 3'b101 : 3'b011;
      chk("an_a", 32'(ifa.an_n), 32'(an_exp));
      chk("an_b", 32'(ifb.an_n), 32'(an_exp));
      chk("seg_a", 32'(ifa.seg_n), 32'(exp_seg(model_bcd, d, 1'b1)));
      chk("seg_b", 32'(ifb.seg_n), 32'(exp_seg(model_bcd, d, 1'b0)));
    end
  end

  task automatic tick(input logic [7:0] v, input logic l, input logic c);
    @(posedge clk);
    #1;
    clr       = c;
    ifa.value = v;
    ifb.value = v;
    ifa.load  = l;
    ifb.load  = l;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(8'($urandom), 1'b0, 1'b0);
  endtask

  initial begin
    clr       = 1'b1;
    ifa.value = 8'd0;
    ifb.value = 8'd0;
    ifa.load  = 1'b0;
    ifb.load  = 1'b0;
    repeat (2) tick(8'd0, 1'b0, 1'b1);
    tick(8'd0, 1'b0, 1'b0);
    idle(3);
    // Zero converts to 0x000 with done 8 cycles after load.
    tick(8'd0, 1'b1, 1'b0);
    idle(14);
    // Full-scale value, held long enough to scan every digit several times.
    tick(8'd255, 1'b1, 1'b0);
    idle(40);
    // Small value exercises leading-zero blanking on both digits.
    tick(8'd7, 1'b1, 1'b0);
    idle(30);
    // Second load during conversion must be ignored.
    tick(8'd100, 1'b1, 1'b0);
    idle(2);
    tick(8'd42, 1'b1, 1'b0);
    idle(14);
    // Reset in the 4th conversion cycle aborts without a result.
    tick(8'd200, 1'b1, 1'b0);
    idle(3);
    tick(8'd0, 1'b0, 1'b1);
    idle(20);
    for (int i = 0; i < 600; i++)
      tick(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 79) == 0));
    idle(20);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
